writeback_stage: RTL
====================

WRITEBACK_STAGE -- requirements
Module: writeback_stage

Interface
REQ-001 Parameter: XLEN, 64, datapath width; only 64 is supported.
REQ-002 The block SHALL have one clock and a synchronous, active-high reset.
REQ-003 Port: CLK, in, 1, sole clock; all state updates on posedge.
REQ-004 Port: reset, in, 1, synchronous active-high reset.
REQ-005 Port: MEM_V, in, 1, memory-stage instruction valid.
REQ-006 Port: MEM_REG_WE, in, 1, instruction writes a destination register.
REQ-007 Port: MEM_DR, in, 5, destination register index.
REQ-008 Port: MEM_WB_SEL, in, 2, source select: 00 ALU, 01 load, 10 PC+4, 11 reserved.
REQ-009 Port: MEM_FUNCT3, in, 3, load width/sign code.
REQ-010 Port: MEM_ADDR_LO, in, 3, byte offset of the load address.
REQ-011 Port: MEM_ALU_RESULT, in, 64, ALU result.
REQ-012 Port: MEM_LD_DATA, in, 64, raw aligned doubleword from data memory.
REQ-013 Port: MEM_PC, in, 64, instruction PC.
REQ-014 Port: STALL, in, 1, hold the writeback latch.
REQ-015 Port: DR, out, 5, register-file write index.
REQ-016 Port: WB_DATA, out, 64, register-file write data.
REQ-017 Port: ST_REG, out, 1, register-file write enable.
REQ-018 Port: WB_V, out, 1, writeback latch valid.

Function
REQ-019 On each posedge with reset low and STALL low, the block SHALL capture all MEM_* inputs into the writeback latch; with STALL high the latch SHALL hold.
REQ-020 Latency SHALL be one cycle: inputs sampled at edge N drive DR/WB_DATA/ST_REG after edge N; the register file commits at edge N+1.
REQ-021 DR, WB_DATA, ST_REG and WB_V SHALL be combinational functions of the latch only, with no input-to-output path.
REQ-022 WB_V SHALL equal the latched MEM_V.
REQ-023 ST_REG SHALL be WB_V AND latched MEM_REG_WE AND (latched DR != 0) AND (latched WB_SEL != 11).
REQ-024 With WB_SEL=00, WB_DATA SHALL equal the latched ALU result.
REQ-025 With WB_SEL=10, WB_DATA SHALL equal latched PC + 4, modulo 2^64.
REQ-026 With WB_SEL=11, WB_DATA SHALL be zero.
REQ-027 With WB_SEL=01, the raw doubleword SHALL be shifted right by 8*ADDR_LO bits, zero-filled from the top, then extracted per FUNCT3.
REQ-028 FUNCT3 extraction: 000 LB sign-extends byte; 001 LH sign-extends half; 010 LW sign-extends word; 011 LD full; 100 LBU, 101 LHU, 110 LWU zero-extend; 111 is treated as LD.
REQ-029 A misaligned offset SHALL raise no error; bytes shifted in from beyond byte 7 SHALL read as zero before extension.
REQ-030 When STALL is held, the outputs SHALL stay constant; the repeated ST_REG write is idempotent and permitted.
REQ-031 With WB_V low, DR and WB_DATA are don't-care and ST_REG SHALL be 0.

Reset
REQ-032 Reset SHALL clear every latch field to zero, giving DR=0, WB_DATA=0, ST_REG=0, WB_V=0 from the first cycle after the edge.
REQ-033 Reset SHALL take priority over STALL and discard any in-flight instruction.

Configuration
REQ-034 Macro WB_INSTRET_EN SHALL add output INSTRET (out, 64), reset to 0, incremented at each posedge where WB_V=1 and STALL=0, wrapping from 2^64-1 to 0.
REQ-035 Without WB_INSTRET_EN, the INSTRET port and counter SHALL be absent, with no other behaviour change.

Structure
REQ-036 A shared package SHALL hold the WB_SEL codes (WB_SEL_ALU, WB_SEL_LOAD, WB_SEL_PC4), the FUNCT3 load codes, and XLEN.
REQ-037 Load extraction SHALL be one combinational sub-module, load_align (in: raw 64, addr_lo 3, funct3 3; out: 64).

Verification
REQ-038 MEM_V=1, WE=1, DR=5, SEL=00, ALU=0x1234 -> next cycle ST_REG=1, DR=5, WB_DATA=0x1234.
REQ-039 LD_DATA=0x00000000_0000_80FF, SEL=01, ADDR_LO=1, FUNCT3=000 -> WB_DATA=0xFFFFFFFF_FFFFFF80; same with FUNCT3=100 -> 0x80.
REQ-040 SEL=10, PC=0xFFFFFFFF_FFFFFFFC -> WB_DATA=0.
REQ-041 DR=0 with WE=1 -> ST_REG=0; SEL=11 with DR=3 -> ST_REG=0, WB_DATA=0.
REQ-042 Valid instruction latched, then STALL=1 for 3 cycles with changing inputs -> outputs unchanged; INSTRET increments once, on the release edge.
REQ-043 Reset asserted together with STALL=1 and MEM_V=1 -> next cycle WB_V=0, ST_REG=0, INSTRET=0.

Source files
------------

// File: rtl/writeback_stage_pkg.sv
// writeback_stage_pkg
//   Shared definitions for the writeback stage: the datapath width, the
//   writeback source-select codes and the load width/sign (FUNCT3) codes.
//   No ports; imported by the interface, the top and the load_align unit.
package writeback_stage_pkg;

  // Only a 64-bit datapath is supported.
  localparam int XLEN = 64;

  typedef enum logic [1:0] {
    WB_SEL_ALU  = 2'b00,
    WB_SEL_LOAD = 2'b01,
    WB_SEL_PC4  = 2'b10,
    WB_SEL_RSVD = 2'b11
  } wb_sel_e;

  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LD  = 3'b011,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101,
    F3_LWU = 3'b110,
    F3_LDX = 3'b111
  } ld_funct3_e;

endpackage

// File: rtl/writeback_stage_if.sv
// writeback_stage_if
//   Bundle between the memory stage and the writeback stage.
//   master : memory-stage side, drives MEM_* and STALL, receives results.
//   slave  : writeback stage, receives MEM_* and STALL, drives DR, WB_DATA,
//            ST_REG, WB_V (and INSTRET when WB_INSTRET_EN is defined).
//   Optional feature macro: WB_INSTRET_EN adds the 64-bit INSTRET signal.
interface writeback_stage_if;
  import writeback_stage_pkg::*;

  logic            MEM_V;
  logic            MEM_REG_WE;
  logic [4:0]      MEM_DR;
  logic [1:0]      MEM_WB_SEL;
  logic [2:0]      MEM_FUNCT3;
  logic [2:0]      MEM_ADDR_LO;
  logic [XLEN-1:0] MEM_ALU_RESULT;
  logic [XLEN-1:0] MEM_LD_DATA;
  logic [XLEN-1:0] MEM_PC;
  logic            STALL;

  logic [4:0]      DR;
  logic [XLEN-1:0] WB_DATA;
  logic            ST_REG;
  logic            WB_V;
`ifdef WB_INSTRET_EN
  logic [XLEN-1:0] INSTRET;
`endif

  modport master (
    output MEM_V, MEM_REG_WE, MEM_DR, MEM_WB_SEL, MEM_FUNCT3, MEM_ADDR_LO,
    output MEM_ALU_RESULT, MEM_LD_DATA, MEM_PC, STALL,
`ifdef WB_INSTRET_EN
    input  INSTRET,
`endif
    input  DR, WB_DATA, ST_REG, WB_V
  );

  modport slave (
    input  MEM_V, MEM_REG_WE, MEM_DR, MEM_WB_SEL, MEM_FUNCT3, MEM_ADDR_LO,
    input  MEM_ALU_RESULT, MEM_LD_DATA, MEM_PC, STALL,
`ifdef WB_INSTRET_EN
    output INSTRET,
`endif
    output DR, WB_DATA, ST_REG, WB_V
  );

endinterface

// File: rtl/writeback_stage_load_align.sv
// load_align
//   Combinational load extraction. The raw aligned doubleword is shifted
//   right by 8*addr_lo (zero-filled from the top, so bytes past byte 7 read
//   as zero on a misaligned access), then the low 1/2/4/8 bytes are sign- or
//   zero-extended according to funct3. funct3=111 behaves as LD.
//   Ports: raw (in, 64), addr_lo (in, 3), funct3 (in, 3), result (out, 64).
module load_align
  import writeback_stage_pkg::*;
(
  input  logic [XLEN-1:0] raw,
  input  logic [2:0]      addr_lo,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] result
);

  logic [XLEN-1:0]   shifted;
  logic signed [7:0]  byte_s;
  logic signed [15:0] half_s;
  logic signed [31:0] word_s;

  assign shifted = raw >> {addr_lo, 3'b000};
  assign byte_s  = shifted[7:0];
  assign half_s  = shifted[15:0];
  assign word_s  = shifted[31:0];

  always_comb begin
    result = shifted;
    case (funct3)
      F3_LB:   result = XLEN'(byte_s);
      F3_LH:   result = XLEN'(half_s);
      F3_LW:   result = XLEN'(word_s);
      F3_LBU:  result = XLEN'(shifted[7:0]);
      F3_LHU:  result = XLEN'(shifted[15:0]);
      F3_LWU:  result = XLEN'(shifted[31:0]);
      default: result = shifted;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// writeback_stage
//   Single-cycle writeback latch. MEM_* inputs are captured on each posedge
//   unless STALL holds the latch; outputs are purely combinational functions
//   of the latch contents (no input-to-output path).
//   Ports:
//     CLK    (in)  sole clock, posedge
//     reset  (in)  synchronous active-high reset, priority over STALL
//     bus    (writeback_stage_if.slave) MEM_* and STALL in; DR, WB_DATA,
//            ST_REG, WB_V out (INSTRET out when WB_INSTRET_EN is defined)
//   Optional feature macro: WB_INSTRET_EN adds a retired-instruction counter
//   incremented on every posedge with WB_V=1 and STALL=0.
module writeback_stage #(
  parameter int XLEN = 64  // only 64 is supported
) (
  input  logic             CLK,
  input  logic             reset,
  writeback_stage_if.slave bus
);
  import writeback_stage_pkg::*;

  logic            vld_p1;
  logic            we_p1;
  logic [4:0]      dr_p1;
  logic [1:0]      sel_p1;
  logic [2:0]      funct3_p1;
  logic [2:0]      addr_lo_p1;
  logic [XLEN-1:0] alu_p1;
  logic [XLEN-1:0] ld_p1;
  logic [XLEN-1:0] pc_p1;

  logic [XLEN-1:0] load_val_p1;
  logic [XLEN-1:0] wb_data_p1;

  // ---- stage p0 -> p1: writeback latch ----
  // Every field is cleared on reset so the outputs are defined zeros from
  // the first cycle after reset, not only the valid bit.
  always_ff @(posedge CLK) begin
    if (reset) begin
      vld_p1     <= 1'b0;
      we_p1      <= 1'b0;
      dr_p1      <= '0;
      sel_p1     <= '0;
      funct3_p1  <= '0;
      addr_lo_p1 <= '0;
      alu_p1     <= '0;
      ld_p1      <= '0;
      pc_p1      <= '0;
    end else if (!bus.STALL) begin
      vld_p1     <= bus.MEM_V;
      we_p1      <= bus.MEM_REG_WE;
      dr_p1      <= bus.MEM_DR;
      sel_p1     <= bus.MEM_WB_SEL;
      funct3_p1  <= bus.MEM_FUNCT3;
      addr_lo_p1 <= bus.MEM_ADDR_LO;
      alu_p1     <= bus.MEM_ALU_RESULT;
      ld_p1      <= bus.MEM_LD_DATA;
      pc_p1      <= bus.MEM_PC;
    end
  end

  // ---- stage p1: result select from latch contents ----
  load_align u_load_align (
    .raw     (ld_p1),
    .addr_lo (addr_lo_p1),
    .funct3  (funct3_p1),
    .result  (load_val_p1)
  );

  always_comb begin
    wb_data_p1 = '0;
    case (sel_p1)
      WB_SEL_ALU:  wb_data_p1 = alu_p1;
      WB_SEL_LOAD: wb_data_p1 = load_val_p1;
      WB_SEL_PC4:  wb_data_p1 = pc_p1 + XLEN'(4);
      default:     wb_data_p1 = '0;
    endcase
  end

  assign bus.WB_V    = vld_p1;
  assign bus.DR      = dr_p1;
  assign bus.WB_DATA = wb_data_p1;
  // x0 is hardwired, and the reserved select never writes.
  assign bus.ST_REG  = vld_p1 && we_p1 && (dr_p1 != 5'd0) &&
                       (sel_p1 != WB_SEL_RSVD);

`ifdef WB_INSTRET_EN
  logic [XLEN-1:0] instret_p1;

  // A held instruction retires once, on the edge that releases the stall.
  always_ff @(posedge CLK) begin
    if (reset) begin
      instret_p1 <= '0;
    end else if (vld_p1 && !bus.STALL) begin
      instret_p1 <= instret_p1 + XLEN'(1);
    end
  end

  assign bus.INSTRET = instret_p1;
`endif

endmodule
